// File: rtl/pa_pkg.sv
// Shared constants for the multi-channel phase accumulator.
// Config target encodings, dither LFSR polynomial/seed and its step function.
package pa_pkg;

    typedef enum logic [1:0] {
        PA_SEL_FCW    = 2'd0,
        PA_SEL_INIT   = 2'd1,
        PA_SEL_OFFSET = 2'd2,
        PA_SEL_RSVD   = 2'd3
    } pa_sel_e;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1.
    localparam logic [31:0] PA_LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] PA_LFSR_SEED = 32'h0000_0001;

    function automatic logic [31:0] pa_lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? PA_LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/pa_lane.sv
// One channel: fcw/init/offset registers, modular accumulator with carry flag, offset+truncate stage.
// Latency: acc/wrap one cycle after en/sync, phase one cycle after v1.
// Backpressure: none; every v1 overwrites phase.
module pa_lane #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             v1,
    input  logic             fcw_wen,
    input  logic             init_wen,
    input  logic             offset_wen,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [WIDTH-1:0] dither,
    output logic [OUT_W-1:0] phase,
    output logic             wrap
);

    logic [WIDTH-1:0] fcw;
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcw    <= '0;
            init   <= '0;
            offset <= '0;
        end else begin
            if (fcw_wen)    fcw    <= cfg_data;
            if (init_wen)   init   <= cfg_data;
            if (offset_wen) offset <= cfg_data;
        end
    end

    // Sync takes priority; its load uses the init value from before any same-cycle write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (sync) begin
            acc  <= init;
            wrap <= 1'b0;
        end else if (en) begin
            {wrap, acc} <= {1'b0, acc} + {1'b0, fcw};
        end
    end

    // Offset and dither wrap modulo 2^WIDTH; their carry is intentionally dropped.
    assign sum = acc + offset + dither;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (v1) begin
            phase <= OUT_W'(sum >> (WIDTH - OUT_W));
        end
    end

endmodule

// File: rtl/phase_acc_mc.sv
// Multi-channel NCO phase accumulator; optional shared LFSR dither under PA_DITHER_EN.
// Latency: en/sync in cycle n -> valid/phase_out in cycle n+2; wrap from cycle n+1.
// Backpressure: none; downstream must accept every valid.
module phase_acc_mc
    import pa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OUT_W = 16,
    parameter int NCH   = 2,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 cfg_wen,
    input  logic [1:0]           cfg_sel,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [WIDTH-1:0]     cfg_data,
    output logic [NCH*OUT_W-1:0] phase_out,
    output logic [NCH-1:0]       wrap,
    output logic                 valid
);

    logic             v1;
    logic [WIDTH-1:0] dither;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1    <= 1'b0;
            valid <= 1'b0;
        end else begin
            v1    <= en | sync;
            valid <= v1;
        end
    end

`ifdef PA_DITHER_EN
    localparam logic [31:0] DITHER_MASK = 32'hFFFF_FFFF >> (32 - (WIDTH - OUT_W));

    logic [31:0] lfsr;

    // The current LFSR state dithers this stage-2 update, then steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= PA_LFSR_SEED;
        end else if (v1) begin
            lfsr <= pa_lfsr_step(lfsr);
        end
    end

    assign dither = WIDTH'(lfsr & DITHER_MASK);
`else
    assign dither = '0;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        logic hit;

        // Channel numbers >= NCH never match any lane, so such writes drop out.
        assign hit = cfg_wen && (cfg_ch == CH_W'(c));

        pa_lane #(
            .WIDTH (WIDTH),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .en         (en),
            .sync       (sync),
            .v1         (v1),
            .fcw_wen    (hit && (cfg_sel == PA_SEL_FCW)),
            .init_wen   (hit && (cfg_sel == PA_SEL_INIT)),
            .offset_wen (hit && (cfg_sel == PA_SEL_OFFSET)),
            .cfg_data   (cfg_data),
            .dither     (dither),
            .phase      (phase_out[c*OUT_W +: OUT_W]),
            .wrap       (wrap[c])
        );
    end

endmodule

// File: tb/tb_phase_acc_mc.sv
// Directed self-checking bench for phase_acc_mc at default parameters (no dither).
module tb_phase_acc_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        sync;
    logic        cfg_wen;
    logic [1:0]  cfg_sel;
    logic [0:0]  cfg_ch;
    logic [31:0] cfg_data;
    logic [31:0] phase_out;
    logic [1:0]  wrap;
    logic        valid;

    int tests = 0;
    int fails = 0;

    phase_acc_mc dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .cfg_wen   (cfg_wen),
        .cfg_sel   (cfg_sel),
        .cfg_ch    (cfg_ch),
        .cfg_data  (cfg_data),
        .phase_out (phase_out),
        .wrap      (wrap),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic ch, input logic [31:0] data);
        cfg_wen  = 1'b1;
        cfg_sel  = sel;
        cfg_ch   = ch;
        cfg_data = data;
        tick();
        cfg_wen  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; sync = 1'b0;
        cfg_wen = 1'b0; cfg_sel = 2'd0; cfg_ch = 1'b0; cfg_data = '0;
        #1;
        tests++; if (phase_out !== 32'h0) begin fails++; $display("FAIL reset_phase: got %h want %h", phase_out, 32'h0); end
        tests++; if (wrap !== 2'b00) begin fails++; $display("FAIL reset_wrap: got %b want %b", wrap, 2'b00); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want %b", valid, 1'b0); end
        tick(); reset = 1'b1; tick();
        // Stream with wrapping channel 1, then reset mid-flight.
        cfg_write(2'd0, 1'b0, 32'h0001_0000);
        cfg_write(2'd1, 1'b1, 32'hFFFF_8000);
        sync = 1'b1; tick(); sync = 1'b0;
        cfg_write(2'd0, 1'b1, 32'h0001_0000);
        en = 1'b1; tick(); tick(); tick();
        #2 reset = 1'b0; en = 1'b0;
        #1;
        tests++; if (phase_out !== 32'h0) begin fails++; $display("FAIL midreset_phase: got %h want %h", phase_out, 32'h0); end
        tests++; if (wrap !== 2'b00) begin fails++; $display("FAIL midreset_wrap: got %b want %b", wrap, 2'b00); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b want %b", valid, 1'b0); end
        tick(); tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_inflight_valid: got %b want %b", valid, 1'b0); end
        reset = 1'b1; tick();
        en = 1'b1; tick(); en = 1'b0; tick();
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL post_reset_valid: got %b want %b", valid, 1'b1); end
        tests++; if (phase_out !== 32'h0) begin fails++; $display("FAIL post_reset_phase: got %h want %h", phase_out, 32'h0); end
    endtask

    task automatic test_basic();
        cfg_write(2'd0, 1'b0, 32'h0001_0000);
        en = 1'b1;
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_lat: valid got %b want %b", valid, 1'b0); end
        tick();
        tests++; if (valid !== 1'b1 || phase_out[15:0] !== 16'h0001) begin fails++; $display("FAIL basic_s1: got v=%b ph=%h want v=1 ph=0001", valid, phase_out[15:0]); end
        tick();
        en = 1'b0;
        tests++; if (valid !== 1'b1 || phase_out[15:0] !== 16'h0002) begin fails++; $display("FAIL basic_s2: got v=%b ph=%h want v=1 ph=0002", valid, phase_out[15:0]); end
        tick();
        tests++; if (valid !== 1'b1 || phase_out[15:0] !== 16'h0003) begin fails++; $display("FAIL basic_s3: got v=%b ph=%h want v=1 ph=0003", valid, phase_out[15:0]); end
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_end_valid: got %b want %b", valid, 1'b0); end
        tests++; if (phase_out[15:0] !== 16'h0003) begin fails++; $display("FAIL basic_hold: got %h want %h", phase_out[15:0], 16'h0003); end
        tests++; if (phase_out[31:16] !== 16'h0000) begin fails++; $display("FAIL basic_ch1: got %h want %h", phase_out[31:16], 16'h0000); end
    endtask

    task automatic test_wrap();
        cfg_write(2'd1, 1'b1, 32'hFFFF_0000);
        sync = 1'b1; tick(); sync = 1'b0;
        tests++; if (wrap !== 2'b00) begin fails++; $display("FAIL wrap_after_sync: got %b want %b", wrap, 2'b00); end
        tick();
        cfg_write(2'd0, 1'b1, 32'h0002_0000);
        en = 1'b1; tick(); en = 1'b0;
        tests++; if (wrap !== 2'b10) begin fails++; $display("FAIL wrap_flag: got %b want %b", wrap, 2'b10); end
        tick();
        tests++; if (valid !== 1'b1 || phase_out[31:16] !== 16'h0001) begin fails++; $display("FAIL wrap_phase: got v=%b ph=%h want v=1 ph=0001", valid, phase_out[31:16]); end
        tests++; if (wrap !== 2'b10) begin fails++; $display("FAIL wrap_hold: got %b want %b", wrap, 2'b10); end
    endtask

    task automatic test_offset();
        cfg_write(2'd1, 1'b0, 32'h0003_0000);
        cfg_write(2'd2, 1'b0, 32'h8000_0000);
        sync = 1'b1; tick(); sync = 1'b0; tick();
        tests++; if (phase_out[15:0] !== 16'h8003) begin fails++; $display("FAIL offset_ch0: got %h want %h", phase_out[15:0], 16'h8003); end
        tests++; if (phase_out[31:16] !== 16'hFFFF) begin fails++; $display("FAIL offset_ch1: got %h want %h", phase_out[31:16], 16'hFFFF); end
        cfg_write(2'd2, 1'b0, 32'hFFFF_0000);
        sync = 1'b1; tick(); sync = 1'b0; tick();
        tests++; if (phase_out[15:0] !== 16'h0002) begin fails++; $display("FAIL offset_wrap: got %h want %h", phase_out[15:0], 16'h0002); end
        tests++; if (wrap !== 2'b00) begin fails++; $display("FAIL offset_no_carry: got %b want %b", wrap, 2'b00); end
    endtask

    task automatic test_sync_en();
        cfg_write(2'd2, 1'b0, 32'h0);
        cfg_write(2'd1, 1'b0, 32'h1234_5678);
        sync = 1'b1; en = 1'b1; tick(); sync = 1'b0; en = 1'b0; tick();
        tests++; if (valid !== 1'b1 || phase_out[15:0] !== 16'h1234) begin fails++; $display("FAIL sync_en_ch0: got v=%b ph=%h want v=1 ph=1234", valid, phase_out[15:0]); end
        tests++; if (phase_out[31:16] !== 16'hFFFF) begin fails++; $display("FAIL sync_en_ch1: got %h want %h", phase_out[31:16], 16'hFFFF); end
        // init write coincident with sync: old init is loaded
        cfg_wen = 1'b1; cfg_sel = 2'd1; cfg_ch = 1'b0; cfg_data = 32'h5555_0000;
        sync = 1'b1; tick(); sync = 1'b0; cfg_wen = 1'b0; tick();
        tests++; if (phase_out[15:0] !== 16'h1234) begin fails++; $display("FAIL sync_old_init: got %h want %h", phase_out[15:0], 16'h1234); end
        sync = 1'b1; tick(); sync = 1'b0; tick();
        tests++; if (phase_out[15:0] !== 16'h5555) begin fails++; $display("FAIL sync_new_init: got %h want %h", phase_out[15:0], 16'h5555); end
        // fcw write coincident with en: old fcw 0x0001_0000 is used
        cfg_wen = 1'b1; cfg_sel = 2'd0; cfg_ch = 1'b0; cfg_data = 32'h0100_0000;
        en = 1'b1; tick(); en = 1'b0; cfg_wen = 1'b0; tick();
        tests++; if (phase_out[15:0] !== 16'h5556) begin fails++; $display("FAIL en_old_fcw: got %h want %h", phase_out[15:0], 16'h5556); end
        tests++; if (phase_out[31:16] !== 16'h0001) begin fails++; $display("FAIL en_ch1: got %h want %h", phase_out[31:16], 16'h0001); end
        // reserved target must not disturb any register
        cfg_write(2'd3, 1'b0, 32'hFFFF_FFFF);
        en = 1'b1; tick(); en = 1'b0; tick();
        tests++; if (phase_out[15:0] !== 16'h5656) begin fails++; $display("FAIL en_new_fcw: got %h want %h", phase_out[15:0], 16'h5656); end
        tests++; if (phase_out[31:16] !== 16'h0003) begin fails++; $display("FAIL rsvd_ch1: got %h want %h", phase_out[31:16], 16'h0003); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_offset();
        test_sync_en();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
